// File: rtl/multisum_scheduler.sv
`timescale 1ns/1ps
// multisum_scheduler: round-robin arbiter sharing one MultiSum adder among
// N_REQ requesters, with a done-edge detector and a watchdog abort path.
module multisum_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*4*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         result,
    output logic                      error,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [DATA_W-1:0]         ms_in0,
    output logic [DATA_W-1:0]         ms_in1,
    output logic [DATA_W-1:0]         ms_in2,
    output logic [DATA_W-1:0]         ms_in3,
    output logic                      ms_start,
    output logic                      ms_reset,
    input  logic [DATA_W-1:0]         ms_sum,
    input  logic                      ms_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [2:0]          last_grant;
    logic                done_q;
    logic                done_rise;
    logic [15:0]         timer;
    logic                err_q;
    logic                pick_valid;
    logic [2:0]          pick;
    logic [4*DATA_W-1:0] pick_ops;
    int unsigned         idx;

    assign done_rise = ms_done & ~done_q;

    // Round-robin pick: first set req bit after last_grant, then its operands
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        pick_ops   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant) + k) % N_REQ;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!pick_valid && i == idx && req[i]) begin
                    pick_valid = 1'b1;
                    pick       = 3'(i);
                end
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(pick) == i)
                pick_ops = req_data[i*4*DATA_W +: 4*DATA_W];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_valid) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (done_rise || timer == TLAST) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand latch, watchdog timer, result capture, grant history
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_id   <= '0;
            last_grant <= 3'(N_REQ - 1);
            ms_in0     <= '0;
            ms_in1     <= '0;
            ms_in2     <= '0;
            ms_in3     <= '0;
            result     <= '0;
            err_q      <= 1'b0;
            timer      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= ms_done;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick;
                        ms_in0   <= pick_ops[0*DATA_W +: DATA_W];
                        ms_in1   <= pick_ops[1*DATA_W +: DATA_W];
                        ms_in2   <= pick_ops[2*DATA_W +: DATA_W];
                        ms_in3   <= pick_ops[3*DATA_W +: DATA_W];
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    // done edge takes priority over a coincident timeout
                    if (done_rise) begin
                        result <= ms_sum;
                        err_q  <= 1'b0;
                    end else if (timer == TLAST) begin
                        result <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

    // Strobes and per-requester ack decode
    always_comb begin
        busy     = (state != IDLE);
        ms_start = (state == ISSUE);
        error    = (state == RESP) && err_q;
        ms_reset = reset || ((state == RESP) && err_q);
        ack      = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            ack[i] = (state == RESP) && (32'(grant_id) == i);
    end

endmodule

// File: tb/tb_multisum_scheduler.sv
`timescale 1ns/1ps
// Directed bench for multisum_scheduler with a small MultiSum stub.
module tb_multisum_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*4*W-1:0] req_data;
    logic [N-1:0]     ack;
    logic [W-1:0]     result;
    logic             error, busy;
    logic [2:0]       grant_id;
    logic [W-1:0]     ms_in0, ms_in1, ms_in2, ms_in3;
    logic             ms_start, ms_reset;
    logic [W-1:0]     ms_sum;
    logic             ms_done = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   starts = 0;
    int   cnt    = 0;
    logic never    = 1'b0;
    logic force_hi = 1'b0;

    multisum_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .result(result), .error(error), .busy(busy),
        .grant_id(grant_id), .ms_in0(ms_in0), .ms_in1(ms_in1),
        .ms_in2(ms_in2), .ms_in3(ms_in3), .ms_start(ms_start),
        .ms_reset(ms_reset), .ms_sum(ms_sum), .ms_done(ms_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ms_start) starts <= starts + 1;

    // MultiSum stub: done pulses two cycles after start unless disabled
    assign ms_sum = ms_in0 + ms_in1 + ms_in2 + ms_in3;
    always @(posedge clk) begin
        ms_done <= force_hi | (cnt == 1);
        if (ms_start && !never) cnt <= 2;
        else if (cnt != 0)      cnt <= cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_start(output int c);
        logic found = 1'b0;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ms_start) begin found = 1'b1; c = cyc; break; end
        end
        check("start_seen", 32'(found), 1);
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output logic [W-1:0] r,
                            output logic e, output int c);
        logic found = 1'b0;
        a = '0; r = '0; e = 1'b0; c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                found = 1'b1; a = ack; r = result; e = error; c = cyc;
                break;
            end
        end
        check("ack_seen", 32'(found), 1);
    endtask

    logic [N-1:0] a;
    logic [W-1:0] r;
    logic         e;
    int           cs, ca, s0;
    logic [W-1:0] exp_sum [N] = '{32'd4, 32'd14, 32'd24, 32'd34};

    initial begin
        // requester i operands: (i+1, 2i+1, 3i+1, 4i+1)
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++)
                req_data[(i*4+k)*W +: W] = 32'((k+1)*i + 1);
        req   = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_result", result, 0);
        check("rst_error", 32'(error), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_msin0", ms_in0, 0);
        check("rst_start", 32'(ms_start), 0);
        check("rst_msreset", 32'(ms_reset), 1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_msreset", 32'(ms_reset), 0);

        // single request
        s0  = starts;
        req = 4'b0001;
        wait_start(cs);
        wait_ack(a, r, e, ca);
        req = '0;
        check("t1_ack", 32'(a), 1);
        check("t1_result", r, 4);
        check("t1_error", 32'(e), 0);
        check("t1_latency", 32'(ca - cs), 4);
        check("t1_msin3", ms_in3, 1);
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_ack_after", 32'(ack), 0);
        check("t1_starts", 32'(starts - s0), 1);

        // all four requesting after reset: order 0,1,2,3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1111;
        for (int j = 0; j < N; j++) begin
            logic [N-1:0] ea;
            ea = 4'b0001 << j;
            wait_ack(a, r, e, ca);
            check("t2_ack", 32'(a), 32'(ea));
            check("t2_result", r, exp_sum[j]);
            req = req & ~a;
        end

        // round-robin wrap: 2 alone, then {1,2} -> 1 before 2
        @(negedge clk);
        req = 4'b0100;
        wait_ack(a, r, e, ca);
        req = '0;
        check("t3_first", 32'(a), 32'b0100);
        check("t3_first_res", r, 24);
        @(negedge clk);
        req = 4'b0110;
        wait_ack(a, r, e, ca);
        check("t3_wrap", 32'(a), 32'b0010);
        check("t3_wrap_res", r, 14);
        req = 4'b0100;
        wait_ack(a, r, e, ca);
        req = '0;
        check("t3_then2", 32'(a), 32'b0100);

        // timeout: done never arrives
        @(negedge clk);
        never = 1'b1;
        req   = 4'b0001;
        wait_start(cs);
        wait_ack(a, r, e, ca);
        req = '0;
        check("t4_ack", 32'(a), 1);
        check("t4_error", 32'(e), 1);
        check("t4_result", r, 0);
        check("t4_msreset", 32'(ms_reset), 1);
        check("t4_latency", 32'(ca - cs), 9);
        @(negedge clk);
        check("t4_msreset_off", 32'(ms_reset), 0);
        check("t4_error_off", 32'(error), 0);
        never = 1'b0;
        req   = 4'b0010;
        wait_ack(a, r, e, ca);
        req = '0;
        check("t4_recover_ack", 32'(a), 32'b0010);
        check("t4_recover_res", r, 14);
        check("t4_recover_err", 32'(e), 0);

        // reset during WAIT
        @(negedge clk);
        never = 1'b1;
        req   = 4'b0100;
        wait_start(cs);
        repeat (2) @(negedge clk);
        check("t5_busy_wait", 32'(busy), 1);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 0);
        check("t5_ack", 32'(ack), 0);
        check("t5_msreset", 32'(ms_reset), 1);
        reset = 1'b0;
        never = 1'b0;
        req   = 4'b1111;
        wait_ack(a, r, e, ca);
        req = '0;
        check("t5_next_grant", 32'(a), 1);
        check("t5_next_res", r, 4);

        // stale done level must not complete; fresh edge coinciding with timeout wins
        @(negedge clk);
        force_hi = 1'b1;
        repeat (3) @(negedge clk);
        req = 4'b0010;
        wait_start(cs);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_ack", 32'(ack), 0);
            check("t6_busy", 32'(busy), 1);
        end
        force_hi = 1'b0;
        repeat (2) @(negedge clk);
        force_hi = 1'b1;
        wait_ack(a, r, e, ca);
        req      = '0;
        force_hi = 1'b0;
        check("t6_ack", 32'(a), 32'b0010);
        check("t6_result", r, 14);
        check("t6_error", 32'(e), 0);
        check("t6_latency", 32'(ca - cs), 9);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
